// File: rtl/wave_xfade_mux.sv
// wave_xfade_mux: N-way waveform selector with percent gain and linear cross-fade.
// Define WAVE_XFADE_PHASE_ALIGN_EN to start each fade-in on the new source's period start.
module wave_xfade_mux #(
  parameter int DATA_W = 16,
  parameter int NUM_SRC = 4,
  localparam int SEL_W = $clog2(NUM_SRC),
  parameter int FADE_LOG2 = 4,
  parameter int FADE_DIV = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      on,
  input  logic [SEL_W-1:0]          sel,
  input  logic [7:0]                amplitude,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_wrap,
  output logic [DATA_W-1:0]         signal_out,
  output logic [SEL_W-1:0]          active_sel,
  output logic                      busy,
  output logic                      led_on,
  output logic [NUM_SRC-1:0]        led_src
);

  localparam int GW = FADE_LOG2 + 1;
  localparam int PW = DATA_W + 11;
  localparam int QW = PW + GW + 1;
  localparam int SH = 8 + FADE_LOG2;
  localparam int CW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam logic [GW-1:0] GMAX = GW'(2 ** FADE_LOG2);
  localparam logic [DATA_W-1:0] MID = DATA_W'(1) << (DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    SWITCH,
    FADE_IN,
    RUN,
    FADE_OUT
  } state_t;

  state_t state, state_d;
  logic [GW-1:0] g, g_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [SEL_W-1:0] asel_d;
  logic step, sel_ok, go;
  logic [DATA_W-1:0] src_cur;
  logic [NUM_SRC-1:0] hot;
`ifdef WAVE_XFADE_PHASE_ALIGN_EN
  logic wrap_cur;
`else
  logic wrap_unused;
`endif

  logic [7:0] amp_c;
  logic [14:0] amp_m;
  logic [8:0] amp_q8;
  logic signed [DATA_W:0] dev;
  logic signed [PW-1:0] p1_d, p1_q;
  logic [GW-1:0] g_q;
  logic z_q;
  logic signed [QW-1:0] p2, y_w;

  always_comb begin
    src_cur = MID;
    hot = '0;
`ifdef WAVE_XFADE_PHASE_ALIGN_EN
    wrap_cur = 1'b0;
`endif
    for (int k = 0; k < NUM_SRC; k++) begin
      if (active_sel == SEL_W'(k)) begin
        src_cur = src_data[k*DATA_W +: DATA_W];
        hot[k] = 1'b1;
`ifdef WAVE_XFADE_PHASE_ALIGN_EN
        wrap_cur = src_wrap[k];
`endif
      end
    end
  end

  assign sel_ok = {1'b0, sel} < (SEL_W + 1)'(NUM_SRC);
  assign step = (cnt == CW'(FADE_DIV - 1));

`ifdef WAVE_XFADE_PHASE_ALIGN_EN
  assign go = sel_ok && (sel == active_sel) && wrap_cur;
`else
  assign go = sel_ok;
  assign wrap_unused = ^src_wrap;
`endif

  always_comb begin
    state_d = state;
    g_d = g;
    asel_d = active_sel;
    unique case (state)
      IDLE: begin
        g_d = '0;
        if (on) begin
          state_d = SWITCH;
          asel_d = sel;
        end
      end
      SWITCH: begin
        g_d = '0;
        asel_d = sel;
        if (go) state_d = FADE_IN;
      end
      FADE_IN: begin
        if (sel != active_sel) begin
          state_d = FADE_OUT;
        end else if (g == GMAX) begin
          state_d = RUN;
        end else if (step) begin
          g_d = g + GW'(1);
          if (g + GW'(1) == GMAX) state_d = RUN;
        end
      end
      RUN: begin
        g_d = GMAX;
        if (sel != active_sel) state_d = FADE_OUT;
      end
      FADE_OUT: begin
        if (sel == active_sel) begin
          state_d = FADE_IN;
        end else if (g == '0) begin
          state_d = SWITCH;
          asel_d = sel;
        end else if (step) begin
          g_d = g - GW'(1);
          if (g == GW'(1)) begin
            state_d = SWITCH;
            asel_d = sel;
          end
        end
      end
      default: begin
        state_d = IDLE;
        g_d = '0;
      end
    endcase
    // Output enable overrides everything, including a pending sel change
    if (!on) begin
      state_d = IDLE;
      g_d = '0;
      asel_d = active_sel;
    end
  end

  always_comb begin
    if (state_d != state || step) cnt_d = '0;
    else cnt_d = cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      g <= '0;
      cnt <= '0;
      active_sel <= '0;
      led_on <= 1'b0;
    end else begin
      state <= state_d;
      g <= g_d;
      cnt <= cnt_d;
      active_sel <= asel_d;
      led_on <= on;
    end
  end

  assign busy = (state == SWITCH) || (state == FADE_IN) ||
                (state == FADE_OUT);
  assign led_src = (state != IDLE) ? hot : '0;

  assign amp_c = (amplitude > 8'd100) ? 8'd100 : amplitude;
  assign amp_m = 15'(amp_c) * 15'd164;
  assign amp_q8 = 9'(amp_m >> 6);
  assign dev = $signed({1'b0, src_cur}) - $signed({1'b0, MID});
  assign p1_d = PW'(dev) * PW'($signed({1'b0, amp_q8}));
  assign p2 = QW'(p1_q) * QW'($signed({1'b0, g_q}));
  assign y_w = QW'($signed({1'b0, MID})) + (p2 >>> SH);

  // z_q marks samples taken in IDLE or while disabled; they must emit 0, not MID
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_q <= '0;
      g_q <= '0;
      z_q <= 1'b1;
      signal_out <= '0;
    end else begin
      p1_q <= p1_d;
      g_q <= g;
      z_q <= !on || (state == IDLE);
      if (!on || z_q) signal_out <= '0;
      else if (y_w[QW-1]) signal_out <= '0;
      else if (|y_w[QW-2:DATA_W]) signal_out <= '1;
      else signal_out <= y_w[DATA_W-1:0];
    end
  end

endmodule

// File: tb/tb_wave_xfade_mux.sv
// tb_wave_xfade_mux: directed fades, gain math and enable/reset checks.
// Expected samples queue up at drive time and are compared two clocks later.
module tb_wave_xfade_mux;

  logic clk = 1'b0;
  logic rst;
  logic on;
  logic [1:0] sel;
  logic [7:0] amplitude;
  logic [63:0] src_data;
  logic [3:0] src_wrap;
  logic [15:0] signal_out;
  logic [1:0] active_sel;
  logic busy, led_on;
  logic [3:0] led_src;

  logic on3;
  logic [1:0] sel3;
  logic [47:0] src3;
  logic [2:0] wrap3;
  logic [15:0] out3;
  logic [1:0] asel3;
  logic busy3, ledon3;
  logic [2:0] led3;

  int n_chk = 0;
  int n_err = 0;
  logic [15:0] eq[$];
  string tq[$];

  localparam logic [15:0] MID = 16'h8000;

  always #5 clk = ~clk;

  wave_xfade_mux dut (
    .clk(clk), .rst(rst), .on(on), .sel(sel),
    .amplitude(amplitude), .src_data(src_data),
    .src_wrap(src_wrap), .signal_out(signal_out),
    .active_sel(active_sel), .busy(busy),
    .led_on(led_on), .led_src(led_src)
  );

  wave_xfade_mux #(.NUM_SRC(3)) u3 (
    .clk(clk), .rst(rst), .on(on3), .sel(sel3),
    .amplitude(8'd100), .src_data(src3),
    .src_wrap(wrap3), .signal_out(out3),
    .active_sel(asel3), .busy(busy3),
    .led_on(ledon3), .led_src(led3)
  );

  function automatic logic [15:0] f(input logic [15:0] s,
                                    input int amp, input int gg);
    int ac;
    longint d, p, y;
    ac = (amp > 100) ? 100 : amp;
    d = longint'(s) - 64'sd32768;
    p = d * longint'((ac * 164) >> 6) * longint'(gg);
    y = 64'sd32768 + (p >>> 12);
    if (y < 0) y = 0;
    if (y > 65535) y = 65535;
    return 16'(y);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [15:0] e);
    eq.push_back(e);
    tq.push_back(tag);
    @(posedge clk);
    #1;
    if (eq.size() >= 2) chk(tq.pop_front(), 32'(signal_out), 32'(eq.pop_front()));
  endtask

  task automatic flush();
    eq.delete();
    tq.delete();
  endtask

  task automatic fcyc(input string tag, input logic [15:0] s, input int gg);
    cyc(tag, f(s, int'(amplitude), gg));
  endtask

  task automatic set_src(input int k, input logic [15:0] v);
    src_data[k*16 +: 16] = v;
  endtask

  task automatic switch_phase(input int s);
`ifdef WAVE_XFADE_PHASE_ALIGN_EN
    repeat (3) cyc("sw_wait", MID);
    src_wrap[s] = 1'b1;
    cyc("sw_wrap", MID);
    src_wrap = '0;
`else
    cyc("switch", MID);
    chk("sw_idx", 32'(s), 32'(active_sel));
`endif
  endtask

  task automatic fade_in(input logic [15:0] s, input int s_idx);
    for (int gg = 0; gg < 16; gg++) begin
      chk("fi_busy", 32'(busy), 32'd1);
      chk("fi_led", 32'(led_src), 32'(4'b1 << s_idx));
      fcyc("fade_in", s, gg);
    end
    chk("run_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout, observed running expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; on = 1'b0; sel = 2'd0; amplitude = 8'd100;
    src_data = '0; src_wrap = '0;
    on3 = 1'b0; sel3 = 2'd0; src3 = '0; wrap3 = '0;
    set_src(0, 16'hC000); set_src(1, 16'hE000);
    set_src(2, 16'h4000); set_src(3, 16'h2000);
    src3[16 +: 16] = 16'hC000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", 32'(signal_out), 32'd0);
    chk("rst_asel", 32'(active_sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ledon", 32'(led_on), 32'd0);
    chk("rst_ledsrc", 32'(led_src), 32'd0);

    rst = 1'b0; on = 1'b1; sel = 2'd0;
    cyc("idle", 16'h0000);
    chk("ledon", 32'(led_on), 32'd1);
    chk("sw_busy", 32'(busy), 32'd1);
    switch_phase(0);
    fade_in(16'hC000, 0);
    chk("run_led", 32'(led_src), 32'b0001);
    repeat (3) fcyc("run_c000", 16'hC000, 16);

    set_src(0, 16'hFFFF); amplitude = 8'd50;
    repeat (3) fcyc("amp50_hi", 16'hFFFF, 16);
    set_src(0, 16'h0000);
    repeat (3) fcyc("amp50_lo", 16'h0000, 16);
    set_src(0, 16'hFFFF); amplitude = 8'd200;
    repeat (3) fcyc("amp_clamp", 16'hFFFF, 16);
    amplitude = 8'd0;
    repeat (3) fcyc("amp0", 16'hFFFF, 16);
    set_src(0, 16'hC000); amplitude = 8'd100;
    repeat (3) fcyc("run_back", 16'hC000, 16);

    sel = 2'd2;
    chk("fo_asel0", 32'(active_sel), 32'd0);
    fcyc("fo_run", 16'hC000, 16);
    for (int j = 16; j >= 1; j--) begin
      chk("fo_asel", 32'(active_sel), 32'd0);
      chk("fo_busy", 32'(busy), 32'd1);
      fcyc("fade_out", 16'hC000, j);
    end
    chk("sw_asel2", 32'(active_sel), 32'd2);
    switch_phase(2);
    fade_in(16'h4000, 2);
    repeat (2) fcyc("run_4000", 16'h4000, 16);

    sel = 2'd1;
    fcyc("rv_run", 16'h4000, 16);
    for (int j = 16; j >= 10; j--) fcyc("rv_out", 16'h4000, j);
    sel = 2'd2;
    fcyc("rv_g9_out", 16'h4000, 9);
    chk("rv_asel", 32'(active_sel), 32'd2);
    fcyc("rv_g9_in", 16'h4000, 9);
    for (int gg = 10; gg < 16; gg++) begin
      chk("rv_asel_in", 32'(active_sel), 32'd2);
      fcyc("rv_in", 16'h4000, gg);
    end
    chk("rv_run_busy", 32'(busy), 32'd0);
    repeat (2) fcyc("rv_run2", 16'h4000, 16);

    on = 1'b0;
    flush();
    @(posedge clk);
    #1;
    chk("off_out", 32'(signal_out), 32'd0);
    chk("off_busy", 32'(busy), 32'd0);
    chk("off_led", 32'(led_src), 32'd0);
    chk("off_ledon", 32'(led_on), 32'd0);
    repeat (2) cyc("off_idle", 16'h0000);

    on = 1'b1; sel = 2'd0;
    cyc("idle2", 16'h0000);
    switch_phase(0);
    for (int gg = 0; gg < 5; gg++) fcyc("fi2", 16'hC000, gg);
    on = 1'b0;
    flush();
    @(posedge clk);
    #1;
    chk("fi_off_out", 32'(signal_out), 32'd0);
    chk("fi_off_busy", 32'(busy), 32'd0);
    chk("fi_off_led", 32'(led_src), 32'd0);

    on = 1'b1; sel = 2'd1;
    cyc("idle3", 16'h0000);
    switch_phase(1);
    for (int gg = 0; gg < 6; gg++) fcyc("fi3", 16'hE000, gg);
    chk("fi3_asel", 32'(active_sel), 32'd1);
    rst = 1'b1;
    flush();
    @(posedge clk);
    #1;
    chk("mrst_out", 32'(signal_out), 32'd0);
    chk("mrst_asel", 32'(active_sel), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_ledon", 32'(led_on), 32'd0);
    chk("mrst_ledsrc", 32'(led_src), 32'd0);
    rst = 1'b0; on = 1'b0;

    on3 = 1'b1; sel3 = 2'd3;
    repeat (4) @(posedge clk);
    #1;
    chk("oor_out", 32'(out3), 32'h8000);
    chk("oor_led", 32'(led3), 32'd0);
    chk("oor_busy", 32'(busy3), 32'd1);
    chk("oor_asel", 32'(asel3), 32'd3);
`ifndef WAVE_XFADE_PHASE_ALIGN_EN
    sel3 = 2'd1;
    @(posedge clk);
    #1;
    chk("n3_led", 32'(led3), 32'b010);
    chk("n3_busy", 32'(busy3), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("n3_g0", 32'(out3), 32'(f(16'hC000, 100, 0)));
    @(posedge clk);
    #1;
    chk("n3_g1", 32'(out3), 32'(f(16'hC000, 100, 1)));
    @(posedge clk);
    #1;
    chk("n3_g2", 32'(out3), 32'(f(16'hC000, 100, 2)));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
